// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Brief    : Shared types and sizing helper for the multiport register file.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_clear_fsm.sv
`default_nettype none
// ============================================================================
// Module   : regfile_clear_fsm
// Brief    : Sweep engine that zeroes the register array one entry per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam int unsigned      c_DEPTH = depth_of(ADDR_W);
    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(c_DEPTH - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic              r_busy;
    logic              w_done;

    assign w_done = (r_state == CLEAR) && (r_clr_ptr == c_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= CLEAR;
            r_clr_ptr <= '0;
            r_busy    <= 1'b1;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
                    if (w_done) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    // Requests arriving mid-sweep never reach here, so they cannot restart it.
                    if (clear_req) begin
                        r_clr_ptr <= '0;
                        r_state   <= CLEAR;
                        r_busy    <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= CLEAR;
                    r_clr_ptr <= '0;
                    r_busy    <= 1'b1;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign clr_we   = (r_state == CLEAR);
    assign clr_addr = r_clr_ptr;

endmodule
`default_nettype wire

// File: rtl/regfile_multiport.sv
`default_nettype none
// ============================================================================
// Module   : regfile_multiport
// Brief    : 1-write / NUM_RD-read register file with sweep clear.
//            Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     clear_req,
    output logic                     busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_drop,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data
);

    localparam int unsigned c_DEPTH = depth_of(ADDR_W);

    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic              r_wr_drop;
    logic              w_busy;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_zero_en;
    logic              w_wr_ok;

    regfile_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear_req (clear_req),
        .busy      (w_busy),
        .clr_we    (w_clr_we),
        .clr_addr  (w_clr_addr)
    );

    assign w_zero_en = (ZERO_REG != 0);
    assign w_wr_ok   = wr_en && !w_busy && !(w_zero_en && (wr_addr == '0));

    // Sweep has priority; a write on the clear_req edge lands and is overwritten later.
    always_ff @(posedge clock) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_drop <= 1'b0;
        end else begin
            r_wr_drop <= wr_en && w_busy;
        end
    end

    generate
        for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
            logic [ADDR_W-1:0] w_raddr;
            logic [DATA_W-1:0] w_rdata;
            logic              w_zero_hit;

            assign w_raddr    = rd_addr[k*ADDR_W +: ADDR_W];
            assign w_zero_hit = w_zero_en && (w_raddr == '0);

`ifdef REGFILE_BYPASS_EN
            logic w_fwd;
            // w_wr_ok already excludes busy and the hard-wired zero entry.
            assign w_fwd = w_wr_ok && (w_raddr == wr_addr);
`endif

            always_comb begin
                w_rdata = r_mem[w_raddr];
`ifdef REGFILE_BYPASS_EN
                if (w_fwd) begin
                    w_rdata = wr_data;
                end
`endif
                if (w_busy || w_zero_hit) begin
                    w_rdata = '0;
                end
            end

            assign rd_data[k*DATA_W +: DATA_W] = w_rdata;
        end
    endgenerate

    assign busy    = w_busy;
    assign wr_drop = r_wr_drop;

endmodule
`default_nettype wire

// File: tb/tb_regfile_multiport.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_multiport
// Brief    : Directed vector bench for regfile_multiport (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_multiport;

    logic        clock;
    logic        reset_n;
    logic        clear_req;
    logic        busy;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_drop;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t tbl [9];

    regfile_multiport #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .NUM_RD   (2),
        .ZERO_REG (1)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear_req (clear_req),
        .busy      (busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_drop   (wr_drop),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Called at a negedge right after reset release; counts cycles with busy high.
    task automatic measure_busy(input string name);
        int         cnt;
        logic [31:0] rd_ok;
        cnt   = 0;
        rd_ok = 32'd1;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (!busy) break;
            cnt++;
            if (rd_data[31:0] !== 32'h0) rd_ok = 32'd0;
            @(negedge clock);
        end
        check({name, " busy_len"}, cnt, 32);
        check({name, " rd_zero_while_busy"}, rd_ok, 32'd1);
    endtask

    initial begin
        logic [31:0] exp_byp;
        int          cnt;

        tbl[0] = '{1'b1, 5'd7,  32'hDEADBEEF, 5'd5,  5'd6,  32'h0,        32'h0};
        tbl[1] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'hDEADBEEF, 32'hDEADBEEF};
        tbl[2] = '{1'b1, 5'd0,  32'h00001234, 5'd7,  5'd0,  32'hDEADBEEF, 32'h0};
        tbl[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
        tbl[4] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd7,  5'd1,  32'hDEADBEEF, 32'h0};
        tbl[5] = '{1'b1, 5'd1,  32'h00000001, 5'd31, 5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF};
        tbl[6] = '{1'b1, 5'd7,  32'h12345678, 5'd1,  5'd31, 32'h00000001, 32'hFFFFFFFF};
        tbl[7] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd1,  32'h12345678, 32'h00000001};
        tbl[8] = '{1'b0, 5'd0,  32'h0,        5'd2,  5'd0,  32'h0,        32'h0};

        reset_n   = 1'b0;
        clear_req = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = 5'd0;
        wr_data   = 32'h0;
        rd_addr   = {5'd0, 5'd5};

        // Reset state and initial sweep
        repeat (2) @(negedge clock);
        #1;
        check("reset busy", {31'd0, busy}, 32'd1);
        check("reset wr_drop", {31'd0, wr_drop}, 32'd0);
        check("reset rd0", rd_data[31:0], 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        measure_busy("t1");

        // Table vectors: reads reflect array contents before the edge's write
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            wr_en   = tbl[i].we;
            wr_addr = tbl[i].wa;
            wr_data = tbl[i].wd;
            rd_addr = {tbl[i].ra1, tbl[i].ra0};
            #1;
            check($sformatf("vec%0d rd0", i), rd_data[31:0], tbl[i].e0);
            check($sformatf("vec%0d rd1", i), rd_data[63:32], tbl[i].e1);
            check($sformatf("vec%0d wr_drop", i), {31'd0, wr_drop}, 32'd0);
        end
        @(negedge clock);
        wr_en = 1'b0;

        // Clear sweep with a dropped write and an ignored second clear_req
        wr_en   = 1'b1;
        wr_addr = 5'd3;
        wr_data = 32'h00000033;
        @(negedge clock);
        wr_en   = 1'b0;
        rd_addr = {5'd7, 5'd3};
        #1;
        check("t4 pre rd3", rd_data[31:0], 32'h00000033);
        clear_req = 1'b1;
        @(negedge clock);
        clear_req = 1'b0;
        cnt = 0;
        for (int n = 1; n <= 60; n++) begin
            #1;
            if (!busy) break;
            cnt++;
            if (n == 2) check("t4 rd while busy", rd_data[31:0], 32'h0);
            if (n == 4) check("t4 drop before", {31'd0, wr_drop}, 32'd0);
            if (n == 5) check("t4 drop pulse", {31'd0, wr_drop}, 32'd1);
            if (n == 6) check("t4 drop after", {31'd0, wr_drop}, 32'd0);
            wr_en     = (n == 4);
            wr_addr   = 5'd3;
            wr_data   = 32'hCAFE0003;
            clear_req = (n == 6);
            @(negedge clock);
        end
        wr_en     = 1'b0;
        clear_req = 1'b0;
        check("t4 busy_len", cnt, 32);
        #1;
        check("t4 post rd3", rd_data[31:0], 32'h0);
        check("t4 post rd7", rd_data[63:32], 32'h0);

        // Reset in the middle of a sweep restarts it from entry 0
        @(negedge clock);
        wr_en   = 1'b1;
        wr_addr = 5'd12;
        wr_data = 32'h0000C0DE;
        @(negedge clock);
        wr_en = 1'b0;
        clear_req = 1'b1;
        @(negedge clock);
        clear_req = 1'b0;
        repeat (9) @(negedge clock);
        reset_n = 1'b0;
        wr_en   = 1'b1;
        wr_addr = 5'd13;
        wr_data = 32'h0000BEEF;
        #1;
        check("t5 busy in reset", {31'd0, busy}, 32'd1);
        check("t5 drop in reset", {31'd0, wr_drop}, 32'd0);
        repeat (2) @(negedge clock);
        wr_en   = 1'b0;
        reset_n = 1'b1;
        rd_addr = {5'd13, 5'd0};
        measure_busy("t5");
        rd_addr = {5'd13, 5'd12};
        #1;
        check("t5 rd12 cleared", rd_data[31:0], 32'h0);
        check("t5 rd13 lost", rd_data[63:32], 32'h0);

        // Same-cycle read of the address being written
`ifdef REGFILE_BYPASS_EN
        exp_byp = 32'hA5A5A5A5;
`else
        exp_byp = 32'h0;
`endif
        @(negedge clock);
        wr_en   = 1'b1;
        wr_addr = 5'd9;
        wr_data = 32'hA5A5A5A5;
        rd_addr = {5'd9, 5'd9};
        #1;
        check("t6 rdw port0", rd_data[31:0], exp_byp);
        check("t6 rdw port1", rd_data[63:32], exp_byp);
        @(negedge clock);
        wr_en = 1'b0;
        #1;
        check("t6 after write", rd_data[31:0], 32'hA5A5A5A5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
